// File: rtl/cascade_stage_sequencer_if.sv
// cascade_stage_sequencer_if
// Feature-evaluator handshake between the cascade stage sequencer and the
// weak-classifier feature evaluator.
//   feat_req_valid / feat_req_ready : request handshake (sequencer -> evaluator)
//   feat_req_idx                    : global feature index of the request
//   feat_rsp_valid / feat_rsp_value : in-order signed vote (evaluator -> sequencer)
// Modports: master = sequencer side, slave = evaluator side.
interface cascade_stage_sequencer_if #(
  parameter int ACC_W      = 24,
  parameter int FEAT_IDX_W = 12
);
  logic                    feat_req_valid;
  logic                    feat_req_ready;
  logic [FEAT_IDX_W-1:0]   feat_req_idx;
  logic                    feat_rsp_valid;
  logic signed [ACC_W-1:0] feat_rsp_value;

  modport master (
    output feat_req_valid, feat_req_idx,
    input  feat_req_ready, feat_rsp_valid, feat_rsp_value
  );

  modport slave (
    input  feat_req_valid, feat_req_idx,
    output feat_req_ready, feat_rsp_valid, feat_rsp_value
  );
endinterface

// File: rtl/cascade_stage_sequencer.sv
// cascade_stage_sequencer
// Walks the Haar-cascade stages of one detection window, issues weak-classifier
// feature requests, accumulates the signed votes with saturation and compares
// each stage sum against its threshold to advance or early-reject the window.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, abort       : window start (IDLE only), synchronous abort to IDLE
//   busy, done         : not-IDLE flag, one-cycle verdict-ready pulse
//   face, exit_stage   : verdict and rejecting stage (NUM_STAGES when passed)
//   thr_stage          : registered stage index driving the lookup tables
//   thr_value, stage_len : combinational lookup results for thr_stage
//   feat               : feature evaluator handshake (master side)
module cascade_stage_sequencer #(
  parameter int NUM_STAGES = 22,
  parameter int STAGE_W    = 5,
  parameter int ACC_W      = 24,
  parameter int FRAC_W     = 12,
  parameter int CNT_W      = 8,
  parameter int FEAT_IDX_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    face,
  output logic [STAGE_W-1:0]      exit_stage,
  output logic [STAGE_W-1:0]      thr_stage,
  input  logic signed [ACC_W-1:0] thr_value,
  input  logic [CNT_W-1:0]        stage_len,
  cascade_stage_sequencer_if.master feat
);

  // Catch parameter sets that cannot represent the fixed-point format or the
  // "all stages passed" exit code.
  if (FRAC_W >= ACC_W || NUM_STAGES >= (1 << STAGE_W)) begin : g_bad_params
    $error("cascade_stage_sequencer: inconsistent parameters");
  end

  typedef enum logic [2:0] {IDLE, LOAD, RUN, COMPARE, DONE} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [STAGE_W-1:0]      LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [STAGE_W-1:0]      ALL_PASSED = STAGE_W'(NUM_STAGES);

  state_t                  state, next_state;
  logic [STAGE_W-1:0]      stage;
  logic signed [ACC_W-1:0] acc, thr_r, acc_sat;
  logic [CNT_W-1:0]        len_r, issue_cnt, rsp_cnt;
  logic [FEAT_IDX_W-1:0]   req_idx;
  logic [ACC_W:0]          sum_wide;
  logic                    req_fire, rsp_take, pass, abort_hit;

  assign thr_stage         = stage;
  assign feat.feat_req_idx = req_idx;

  // One extra bit catches overflow; on overflow the sign of the true sum
  // picks which rail to pin to, so the accumulator never wraps.
  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {feat.feat_rsp_value[ACC_W-1], feat.feat_rsp_value};
    acc_sat  = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake decode; abort overrides every other transition.
  always_comb begin
    next_state          = state;
    busy                = (state != IDLE);
    done                = (state == DONE);
    feat.feat_req_valid = (state == RUN) && (issue_cnt < len_r);
    req_fire            = feat.feat_req_valid && feat.feat_req_ready;
    rsp_take            = (state == RUN) && feat.feat_rsp_valid && (rsp_cnt < len_r);
    pass                = (acc >= thr_r);
    abort_hit           = abort && (state != IDLE);
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    next_state = RUN;
      RUN:     if (rsp_cnt == len_r) next_state = COMPARE;
      COMPARE: next_state = (pass && stage != LAST_STAGE) ? LOAD : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort_hit) next_state = IDLE;
  end

  // Datapath. The stage index only moves on edges that enter LOAD, so the
  // lookup tables have a full cycle to settle before LOAD latches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage      <= '0;
      acc        <= '0;
      thr_r      <= '0;
      len_r      <= '0;
      issue_cnt  <= '0;
      rsp_cnt    <= '0;
      req_idx    <= '0;
      face       <= 1'b0;
      exit_stage <= '0;
    end else if (!abort_hit) begin
      case (state)
        IDLE: begin
          if (start) begin
            stage     <= '0;
            acc       <= '0;
            req_idx   <= '0;
            issue_cnt <= '0;
            rsp_cnt   <= '0;
          end
        end
        LOAD: begin
          thr_r     <= thr_value;
          len_r     <= stage_len;
          acc       <= '0;
          issue_cnt <= '0;
          rsp_cnt   <= '0;
        end
        RUN: begin
          if (req_fire) begin
            req_idx   <= req_idx + FEAT_IDX_W'(1);
            issue_cnt <= issue_cnt + CNT_W'(1);
          end
          if (rsp_take) begin
            acc     <= acc_sat;
            rsp_cnt <= rsp_cnt + CNT_W'(1);
          end
        end
        COMPARE: begin
          if (pass) begin
            if (stage != LAST_STAGE) begin
              stage <= stage + STAGE_W'(1);
            end else begin
              face       <= 1'b1;
              exit_stage <= ALL_PASSED;
            end
          end else begin
            face       <= 1'b0;
            exit_stage <= stage;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cascade_stage_sequencer.sv
// tb_cascade_stage_sequencer
// Self-checking bench for cascade_stage_sequencer. A behavioural model derives
// each window's verdict and request count from the stage tables and the vote
// value; a monitor compares requests, stalls and verdicts every cycle, and the
// directed scenarios add hand-computed literal expectations.
module tb_cascade_stage_sequencer;
  localparam int NUM_STAGES  = 22;
  localparam int STAGE_W     = 5;
  localparam int ACC_W       = 24;
  localparam int FRAC_W      = 12;
  localparam int CNT_W       = 8;
  localparam int FEAT_IDX_W  = 12;
  localparam int CYCLE_LIMIT = 4000;
  localparam logic signed [ACC_W-1:0] ONE = 24'sh001000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, face;
  logic [STAGE_W-1:0]      exit_stage, thr_stage;
  logic signed [ACC_W-1:0] thr_value;
  logic [CNT_W-1:0]        stage_len;

  cascade_stage_sequencer_if #(.ACC_W(ACC_W), .FEAT_IDX_W(FEAT_IDX_W)) fif ();

  cascade_stage_sequencer #(
    .NUM_STAGES(NUM_STAGES), .STAGE_W(STAGE_W), .ACC_W(ACC_W),
    .FRAC_W(FRAC_W), .CNT_W(CNT_W), .FEAT_IDX_W(FEAT_IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .face(face), .exit_stage(exit_stage),
    .thr_stage(thr_stage), .thr_value(thr_value), .stage_len(stage_len),
    .feat(fif)
  );

  always #5 clk = ~clk;

  // Stage tables and evaluator behaviour for the current scenario.
  logic signed [ACC_W-1:0] thr_tab [NUM_STAGES];
  logic [CNT_W-1:0]        len_tab [NUM_STAGES];
  logic signed [ACC_W-1:0] vote = ONE;
  bit ready_toggle = 1'b0;
  bit rand_lat     = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model expectations and monitor state.
  bit exp_face;
  int exp_exit, exp_reqs;
  int exp_idx   = 0;
  int req_count = 0;
  bit mon_en       = 1'b0;
  bit done_allowed = 1'b1;
  bit prev_hold    = 1'b0;
  bit prev_abort   = 1'b0;

  always_comb begin
    thr_value = '0;
    stage_len = '0;
    if (int'(thr_stage) < NUM_STAGES) begin
      thr_value = thr_tab[thr_stage];
      stage_len = len_tab[thr_stage];
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  // Cascade verdict straight from the rules: per stage, sum len votes with
  // clamping to the signed range, reject on the first stage below threshold.
  function automatic void model_window(output bit m_face, output int m_exit, output int m_reqs);
    longint acc;
    m_reqs = 0;
    m_face = 1'b1;
    m_exit = NUM_STAGES;
    for (int s = 0; s < NUM_STAGES; s++) begin
      acc = 0;
      for (int k = 0; k < int'(len_tab[s]); k++) begin
        acc = acc + longint'(vote);
        if (acc > 64'sd8388607)  acc = 64'sd8388607;
        if (acc < -64'sd8388608) acc = -64'sd8388608;
      end
      m_reqs += int'(len_tab[s]);
      if (acc < longint'(thr_tab[s])) begin
        m_face = 1'b0;
        m_exit = s;
        return;
      end
    end
  endfunction

  task automatic applyStimulus(input logic signed [ACC_W-1:0] thr_all, input logic [CNT_W-1:0] len_all,
                               input logic signed [ACC_W-1:0] vote_v, input bit toggle, input bit rl);
    for (int s = 0; s < NUM_STAGES; s++) begin
      thr_tab[s] = thr_all;
      len_tab[s] = len_all;
    end
    vote         = vote_v;
    ready_toggle = toggle;
    rand_lat     = rl;
  endtask

  task automatic start_window();
    model_window(exp_face, exp_exit, exp_reqs);
    exp_idx      = 0;
    req_count    = 0;
    mon_en       = 1'b1;
    done_allowed = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_window(input bit timing_chk, input bit poke_start, input string tag);
    bit seen;
    start_window();
    if (timing_chk) begin
      checkOutput({tag, "_busy_in_load"}, busy, 1);
      checkOutput({tag, "_valid_in_load"}, fif.feat_req_valid, 0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_valid_first_run"}, fif.feat_req_valid, 1);
      checkOutput({tag, "_idx_first_run"}, fif.feat_req_idx, 0);
    end
    seen = 1'b0;
    for (int i = 0; i < CYCLE_LIMIT && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else start = (poke_start && i == 10);
    end
    start = 1'b0;
    checkOutput({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      @(negedge clk);
      checkOutput({tag, "_done_one_cycle"}, done, 0);
      checkOutput({tag, "_idle_after_done"}, busy, 0);
    end
  endtask

  task automatic wait_stage5_run(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < CYCLE_LIMIT && !found; i++) begin
      @(negedge clk);
      if (thr_stage == 5 && fif.feat_req_valid) found = 1'b1;
    end
    checkOutput({tag, "_reached_stage5_run"}, found, 1);
  endtask

  // Feature evaluator: records accepted requests, returns votes in order
  // after 1 (or 1..4) cycles, optionally toggles ready every cycle.
  initial begin
    int     pend[$];
    int     cyc;
    bit     fire;
    cyc = 0;
    fif.feat_req_ready = 1'b1;
    fif.feat_rsp_valid = 1'b0;
    fif.feat_rsp_value = '0;
    forever begin
      @(negedge clk);
      fire = rst_n && fif.feat_req_valid && fif.feat_req_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) pend.delete();
      else if (fire) pend.push_back(cyc + (rand_lat ? int'($urandom_range(1, 4)) : 1) - 1);
      if (pend.size() > 0 && pend[0] <= cyc) begin
        fif.feat_rsp_valid = 1'b1;
        fif.feat_rsp_value = vote;
        void'(pend.pop_front());
      end else begin
        fif.feat_rsp_valid = 1'b0;
        fif.feat_rsp_value = '0;
      end
      fif.feat_req_ready = ready_toggle ? ~fif.feat_req_ready : 1'b1;
    end
  end

  // Monitor: request order, stall stability, request budget and verdicts.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold  = 1'b0;
        prev_abort = 1'b0;
      end else if (mon_en) begin
        if (prev_hold && !prev_abort) checkOutput("req_held_while_stalled", fif.feat_req_valid, 1);
        if (fif.feat_req_valid) begin
          checkOutput("req_idx", fif.feat_req_idx, exp_idx);
          checkOutput("req_within_budget", req_count < exp_reqs, 1);
        end
        if (done) begin
          checkOutput("done_allowed", done_allowed, 1);
          if (done_allowed) begin
            checkOutput("verdict_face", face, exp_face);
            checkOutput("verdict_exit_stage", exit_stage, exp_exit);
            checkOutput("request_count", req_count, exp_reqs);
          end
        end
        if (fif.feat_req_valid && fif.feat_req_ready) begin
          exp_idx++;
          req_count++;
        end
        prev_hold  = fif.feat_req_valid && !fif.feat_req_ready;
        prev_abort = abort;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_face"}, face, 0);
    checkOutput({tag, "_exit_stage"}, exit_stage, 0);
    checkOutput({tag, "_thr_stage"}, thr_stage, 0);
    checkOutput({tag, "_req_valid"}, fif.feat_req_valid, 0);
    checkOutput({tag, "_req_idx"}, fif.feat_req_idx, 0);
  endtask

  initial begin
    applyStimulus(24'sh000000, 8'd2, ONE, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] all stages pass, ready=1");
    run_window(1'b1, 1'b0, "pass_all");
    checkOutput("pass_all_model_reqs", exp_reqs, 44);
    checkOutput("pass_all_face", face, 1);
    checkOutput("pass_all_exit", exit_stage, 22);

    $display("[TB] stage 3 rejects");
    applyStimulus(24'sh000000, 8'd2, ONE, 1'b0, 1'b0);
    thr_tab[3] = 24'sh005000;
    run_window(1'b0, 1'b0, "reject3");
    checkOutput("reject3_model_reqs", exp_reqs, 8);
    checkOutput("reject3_face", face, 0);
    checkOutput("reject3_exit", exit_stage, 3);
    repeat (5) @(negedge clk);
    checkOutput("reject3_no_late_request", fif.feat_req_valid, 0);

    $display("[TB] stalled ready, random latency, start while busy");
    applyStimulus(24'sh000000, 8'd2, ONE, 1'b1, 1'b1);
    run_window(1'b0, 1'b1, "stall");
    checkOutput("stall_face", face, 1);
    checkOutput("stall_exit", exit_stage, 22);
    checkOutput("stall_req_total", req_count, 44);

    $display("[TB] negative saturation");
    applyStimulus(24'sh800001, 8'd4, 24'sh800000, 1'b0, 1'b0);
    run_window(1'b0, 1'b0, "sat_neg");
    checkOutput("sat_neg_model_reqs", exp_reqs, 4);
    checkOutput("sat_neg_face", face, 0);
    checkOutput("sat_neg_exit", exit_stage, 0);

    $display("[TB] positive saturation");
    applyStimulus(24'sh7FFFFF, 8'd4, 24'sh7FF000, 1'b0, 1'b0);
    run_window(1'b0, 1'b0, "sat_pos");
    checkOutput("sat_pos_model_reqs", exp_reqs, 88);
    checkOutput("sat_pos_face", face, 1);
    checkOutput("sat_pos_exit", exit_stage, 22);

    $display("[TB] abort in stage 5");
    applyStimulus(24'sh000000, 8'd2, ONE, 1'b0, 1'b0);
    start_window();
    done_allowed = 1'b0;
    wait_stage5_run("abort");
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_req_valid", fif.feat_req_valid, 0);
    checkOutput("abort_face_kept", face, 1);
    checkOutput("abort_exit_kept", exit_stage, 22);
    repeat (6) @(negedge clk);
    checkOutput("abort_stays_idle", busy, 0);
    run_window(1'b0, 1'b0, "after_abort");
    checkOutput("after_abort_exit", exit_stage, 22);

    $display("[TB] reset in stage 5");
    start_window();
    done_allowed = 1'b0;
    wait_stage5_run("midreset");
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_window(1'b0, 1'b0, "after_reset");
    checkOutput("after_reset_face", face, 1);

    $display("[TB] empty stages");
    applyStimulus(24'shFFF000, 8'd0, ONE, 1'b0, 1'b0);
    run_window(1'b0, 1'b0, "empty_pass");
    checkOutput("empty_pass_model_reqs", exp_reqs, 0);
    checkOutput("empty_pass_face", face, 1);
    checkOutput("empty_pass_reqs", req_count, 0);
    applyStimulus(24'sh001000, 8'd0, ONE, 1'b0, 1'b0);
    run_window(1'b0, 1'b0, "empty_fail");
    checkOutput("empty_fail_face", face, 0);
    checkOutput("empty_fail_exit", exit_stage, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
